// File: rtl/riscv_defs.sv
// Shared RV32I definitions used by the decode and execute stages:
// opcode constants, control encodings and small decode helpers.
package riscv_defs;

    localparam int XLEN_C       = 32;
    localparam int REG_ADDR_W_C = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // IMM_NONE marks instructions without an immediate; their ImmExt is zero.
    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_J    = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    function automatic logic [31:0] extend_imm(input logic [31:0] instr,
                                               input imm_src_e    src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    // funct7[5] only selects subtract for register-register ops; for
    // immediate ops that bit is part of the immediate.
    function automatic alu_ctrl_e alu_decode(input alu_op_e    op,
                                             input logic [2:0] funct3,
                                             input logic       funct7_b5,
                                             input logic       is_rtype);
        alu_ctrl_e ctrl;
        case (op)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ctrl = ALU_SLT;
                    3'b110:  ctrl = ALU_OR;
                    3'b111:  ctrl = ALU_AND;
                    default: ctrl = ALU_ADD;
                endcase
            end
            default:   ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: two combinational read ports, one
// write port, asynchronous clear, and write-through bypass so a reader in
// the same cycle as the writeback sees the new value.
module register_file
    import riscv_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a1_i,
    input  logic [4:0]  a2_i,
    input  logic        we3_i,
    input  logic [4:0]  a3_i,
    input  logic [31:0] wd3_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    // x0 has no storage; it is hardwired to zero on the read side.
    logic [31:0] regs_q [1:31];
    logic        wr_en;

    assign wr_en = we3_i && (a3_i != 5'd0);

    // Storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            regs_q[a3_i] <= wd3_i;
        end
    end

    // Read port 1 with write-through bypass.
    always_comb begin
        rd1_o = 32'h0000_0000;
        if (a1_i == 5'd0) begin
            rd1_o = 32'h0000_0000;
        end else if (wr_en && (a3_i == a1_i)) begin
            rd1_o = wd3_i;
        end else begin
            rd1_o = regs_q[a1_i];
        end
    end

    // Read port 2 with write-through bypass.
    always_comb begin
        rd2_o = 32'h0000_0000;
        if (a2_i == 5'd0) begin
            rd2_o = 32'h0000_0000;
        end else if (wr_en && (a3_i == a2_i)) begin
            rd2_o = wd3_i;
        end else begin
            rd2_o = regs_q[a2_i];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension and register
// read are combinational; everything is captured in the D->E register.
module decode_cycle
    import riscv_defs::*;
#(
    parameter int XLEN       = XLEN_C,
    parameter int REG_ADDR_W = REG_ADDR_W_C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       InstrD,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic                  FlushE,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RDW,
    input  logic [XLEN-1:0]       ResultW,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [2:0]            ALUControlE,
    output logic                  ALUSrcE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       PCPlus4E
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rd_d;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1_d  = InstrD[19:15];
    assign rs2_d  = InstrD[24:20];
    assign rd_d   = InstrD[11:7];

    logic        reg_write_d;
    logic        mem_write_d;
    logic        jump_d;
    logic        branch_d;
    logic        alu_src_d;
    result_src_e result_src_d;
    alu_op_e     alu_op_d;
    imm_src_e    imm_src_d;
    alu_ctrl_e   alu_ctrl_d;
    logic [31:0] imm_ext_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;

    // Main control decode; unknown opcodes fall through as a bubble.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = RES_ALU;
        alu_op_d     = ALUOP_ADD;
        imm_src_d    = IMM_NONE;
        case (opcode)
            OP_LOAD: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = RES_MEM;
                imm_src_d    = IMM_I;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_src_d   = IMM_S;
            end
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op_d    = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = ALUOP_FUNCT;
                imm_src_d   = IMM_I;
            end
            OP_BRANCH: begin
                branch_d  = 1'b1;
                alu_op_d  = ALUOP_SUB;
                imm_src_d = IMM_B;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                jump_d       = 1'b1;
                result_src_d = RES_PC4;
                imm_src_d    = IMM_J;
            end
            default: ;
        endcase
    end

    assign alu_ctrl_d = alu_decode(alu_op_d, funct3, InstrD[30], opcode == OP_RTYPE);
    assign imm_ext_d  = extend_imm(InstrD, imm_src_d);

    register_file u_register_file (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (rs1_d),
        .a2_i  (rs2_d),
        .we3_i (RegWriteW),
        .a3_i  (RDW),
        .wd3_i (ResultW),
        .rd1_o (rd1_d),
        .rd2_o (rd2_d)
    );

    logic                  reg_write_q;
    logic [1:0]            result_src_q;
    logic                  mem_write_q;
    logic                  jump_q;
    logic                  branch_q;
    logic [2:0]            alu_ctrl_q;
    logic                  alu_src_q;
    logic [XLEN-1:0]       rd1_q;
    logic [XLEN-1:0]       rd2_q;
    logic [XLEN-1:0]       imm_ext_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       pc_plus4_q;

    // D->E data fields load every cycle, including during a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_ext_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_ext_q  <= imm_ext_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            pc_q       <= PCD;
            pc_plus4_q <= PCPlus4D;
        end
    end

    // D->E control fields; a flush turns the slot into a bubble and wins
    // over whatever was decoded this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_src_q    <= 1'b0;
        end else if (FlushE) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_src_q    <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign ResultSrcE  = result_src_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUControlE = alu_ctrl_q;
    assign ALUSrcE     = alu_src_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_ext_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases plus randomized
// instructions and writebacks checked against an instruction-level model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_rf [32];

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        j;
        logic        b;
        logic [2:0]  alu;
        logic        as;
        logic [31:0] imm;
    } exp_t;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: ALU operation selected by funct3 for R/I arithmetic.
    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'd0:    return is_sub ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Reference immediates computed as signed integers from the field weights.
    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        int v;
        v = int'(ins[30:20]);
        if (ins[31]) v -= 2048;
        return 32'(v);
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        int v;
        v = int'(ins[30:25]) * 32 + int'(ins[11:7]);
        if (ins[31]) v -= 2048;
        return 32'(v);
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        int v;
        v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
        return 32'(v);
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        int v;
        v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) v -= 1048576;
        return 32'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        e.rw = 0; e.rs = 0; e.mw = 0; e.j = 0; e.b = 0; e.alu = 0; e.as = 0; e.imm = 0;
        case (ins[6:0])
            7'h03: begin e.rw = 1; e.rs = 2'd1; e.as = 1; e.imm = imm_i(ins); end
            7'h23: begin e.mw = 1; e.as = 1; e.imm = imm_s(ins); end
            7'h33: begin e.rw = 1; e.alu = ref_alu(ins[14:12], ins[30]); end
            7'h13: begin e.rw = 1; e.as = 1; e.alu = ref_alu(ins[14:12], 1'b0); e.imm = imm_i(ins); end
            7'h63: begin e.b = 1; e.alu = 3'd1; e.imm = imm_b(ins); end
            7'h6F: begin e.rw = 1; e.j = 1; e.rs = 2'd2; e.imm = imm_j(ins); end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && rd == a) return wd;
        return mdl_rf[a];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {23'h0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE}, 32'h0);
        chk({tag, "_RD1E"}, RD1E, 32'h0);
        chk({tag, "_RD2E"}, RD2E, 32'h0);
        chk({tag, "_ImmExtE"}, ImmExtE, 32'h0);
        chk({tag, "_regs"}, {17'h0, Rs1E, Rs2E, RdE}, 32'h0);
        chk({tag, "_PCE"}, PCE, 32'h0);
        chk({tag, "_PCPlus4E"}, PCPlus4E, 32'h0);
    endtask

    // One decode cycle: drive, clock, compare every output with the model.
    task automatic step(input logic [31:0] ins, input logic fl, input logic we,
                        input logic [4:0] rd, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] pc, x1v, x2v;
        e = ref_decode(ins);
        if (fl) begin
            e.rw = 0; e.rs = 0; e.mw = 0; e.j = 0; e.b = 0; e.alu = 0; e.as = 0;
        end
        x1v = rf_read(ins[19:15], we, rd, wd);
        x2v = rf_read(ins[24:20], we, rd, wd);
        pc  = $urandom;
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = fl;
        RegWriteW = we; RDW = rd; ResultW = wd;
        @(posedge clk); #1;
        chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
        chk("ResultSrcE", 32'(ResultSrcE), 32'(e.rs));
        chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
        chk("JumpE", 32'(JumpE), 32'(e.j));
        chk("BranchE", 32'(BranchE), 32'(e.b));
        chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        chk("ALUSrcE", 32'(ALUSrcE), 32'(e.as));
        chk("ImmExtE", ImmExtE, e.imm);
        chk("RD1E", RD1E, x1v);
        chk("RD2E", RD2E, x2v);
        chk("Rs1E", 32'(Rs1E), 32'(ins[19:15]));
        chk("Rs2E", 32'(Rs2E), 32'(ins[24:20]));
        chk("RdE", 32'(RdE), 32'(ins[11:7]));
        chk("PCE", PCE, pc);
        chk("PCPlus4E", PCPlus4E, pc + 32'd4);
        if (we && rd != 0) mdl_rf[rd] = wd;
    endtask

    task automatic random_steps(input int n);
        logic [6:0]  ops [7];
        logic [31:0] ins;
        logic [4:0]  rd;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            rd = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom);
            step(ins, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, rd, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl_rf[i] = 32'h0;
        rst = 1'b0; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0; FlushE = 1'b0;
        RegWriteW = 1'b0; RDW = 5'h0; ResultW = 32'h0;
        #3;
        chk_zero("reset_initial");
        InstrD = 32'h0000_006F; PCD = 32'h1234; RegWriteW = 1'b1; RDW = 5'd4; ResultW = 32'h55;
        @(posedge clk); #1;
        chk_zero("reset_held");
        RegWriteW = 1'b0;
        rst = 1'b1;

        // Writeback with same-cycle bypass, then storage read, then x0 write.
        step(32'h0002_81B3, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("bypass_RD1E", RD1E, 32'hDEAD_BEEF);
        chk("bypass_ALUControlE", 32'(ALUControlE), 32'd0);
        chk("bypass_RegWriteE", 32'(RegWriteE), 32'd1);
        step(32'h0002_81B3, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("stored_x5", RD1E, 32'hDEAD_BEEF);
        step(32'h0000_01B3, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
        chk("x0_bypass", RD1E, 32'h0);
        step(32'h0000_01B3, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("x0_stored", RD1E, 32'h0);

        step(32'hFFC1_2303, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("lw_imm", ImmExtE, 32'hFFFF_FFFC);
        chk("lw_resultsrc", 32'(ResultSrcE), 32'd1);
        step(32'h0061_2423, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("sw_imm", ImmExtE, 32'h0000_0008);
        chk("sw_memwrite", 32'(MemWriteE), 32'd1);
        step(32'hFE20_8CE3, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
        chk("beq_alu", 32'(ALUControlE), 32'd1);
        step(32'h0010_00EF, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("jal_imm", ImmExtE, 32'h0000_0800);
        chk("jal_resultsrc", 32'(ResultSrcE), 32'd2);

        step(32'h4094_03B3, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("flush_alu", 32'(ALUControlE), 32'd0);
        chk("flush_rd", 32'(RdE), 32'd7);
        step(32'h4094_03B3, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("sub_alu", 32'(ALUControlE), 32'd1);
        chk("sub_rd", 32'(RdE), 32'd7);
        step(32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("badop_regwrite", 32'(RegWriteE), 32'd0);

        random_steps(300);

        // Asynchronous reset mid-run, then confirm every register reads zero.
        rst = 1'b0;
        #1;
        chk_zero("reset_async");
        for (int i = 0; i < 32; i++) mdl_rf[i] = 32'h0;
        @(posedge clk); #1;
        chk_zero("reset_hold");
        rst = 1'b1;
        for (int i = 1; i < 32; i++)
            step({7'h00, 5'(32 - i), 5'(i), 3'b000, 5'd1, 7'h33}, 1'b0, 1'b0, 5'd0, 32'h0);

        random_steps(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
